// File: rtl/cnn_layer_accel_prefetch_ctrl.sv
// Row prefetch controller: issues one memory read per image row, streams the returned
// pixels into the prefetch buffer and holds each row until the reader consumes it.
module cnn_layer_accel_prefetch_ctrl #(
  parameter int unsigned PIXEL_WIDTH = 16,
  parameter int unsigned CNT_WIDTH   = 10,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                   wr_clk,
  input  logic                   rst,
  input  logic                   job_start,
  input  logic [ADDR_WIDTH-1:0]  job_base_addr,
  input  logic [ADDR_WIDTH-1:0]  job_row_stride,
  input  logic [CNT_WIDTH-1:0]   job_num_cols,
  input  logic [CNT_WIDTH-1:0]   job_num_rows,
  output logic                   job_busy,
  output logic                   job_done,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  output logic [CNT_WIDTH-1:0]   mem_req_len,
  input  logic                   mem_rsp_valid,
  input  logic [PIXEL_WIDTH-1:0] mem_rsp_data,
  output logic                   mem_rsp_ready,
  output logic [PIXEL_WIDTH-1:0] pb_din,
  output logic                   pb_wr_en,
  output logic                   pb_job_fetch_ack,
  output logic                   row_ready,
  input  logic                   row_consumed,
  output logic                   protocol_err
);

  typedef enum logic [2:0] {StIdle, StReq, StStream, StWaitConsume, StDone} state_e;

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  stride_q, stride_d;
  logic [CNT_WIDTH-1:0]   cols_q, cols_d;
  logic [CNT_WIDTH-1:0]   rows_q, rows_d;
  logic [CNT_WIDTH-1:0]   col_cnt_q, col_cnt_d;
  logic [CNT_WIDTH-1:0]   row_idx_q, row_idx_d;
  logic [PIXEL_WIDTH-1:0] din_q, din_d;
  logic                   wr_en_q, wr_en_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   beat;

  assign beat = (state_q == StStream) && mem_rsp_valid;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    cols_d    = cols_q;
    rows_d    = rows_q;
    col_cnt_d = col_cnt_q;
    row_idx_d = row_idx_q;
    wr_en_d   = beat;
    din_d     = beat ? mem_rsp_data : din_q;
    ack_d     = 1'b0;
    // A consume pulse is only legal while a row is being held for the reader.
    err_d     = err_q | (row_consumed && (state_q != StWaitConsume));

    unique case (state_q)
      StIdle: begin
        if (job_start) begin
          if ((job_num_cols != '0) && (job_num_rows != '0)) begin
            addr_d    = job_base_addr;
            stride_d  = job_row_stride;
            cols_d    = job_num_cols;
            rows_d    = job_num_rows;
            col_cnt_d = '0;
            row_idx_d = '0;
            ack_d     = 1'b1;
            state_d   = StReq;
          end else begin
            state_d = StDone;
          end
        end
      end
      StReq: begin
        if (mem_req_ready) state_d = StStream;
      end
      StStream: begin
        if (beat) begin
          col_cnt_d = col_cnt_q + CntOne;
          if (col_cnt_q == cols_q - CntOne) state_d = StWaitConsume;
        end
      end
      StWaitConsume: begin
        if (row_consumed) begin
          if (row_idx_q == rows_q - CntOne) begin
            state_d = StDone;
          end else begin
            row_idx_d = row_idx_q + CntOne;
            addr_d    = addr_q + stride_q;
            col_cnt_d = '0;
            ack_d     = 1'b1;
            state_d   = StReq;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      stride_q  <= '0;
      cols_q    <= '0;
      rows_q    <= '0;
      col_cnt_q <= '0;
      row_idx_q <= '0;
      din_q     <= '0;
      wr_en_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      stride_q  <= stride_d;
      cols_q    <= cols_d;
      rows_q    <= rows_d;
      col_cnt_q <= col_cnt_d;
      row_idx_q <= row_idx_d;
      din_q     <= din_d;
      wr_en_q   <= wr_en_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign job_busy         = (state_q != StIdle);
  assign job_done         = (state_q == StDone);
  assign mem_req_valid    = (state_q == StReq);
  assign mem_req_addr     = addr_q;
  assign mem_req_len      = cols_q;
  assign mem_rsp_ready    = (state_q == StStream);
  assign pb_din           = din_q;
  assign pb_wr_en         = wr_en_q;
  assign pb_job_fetch_ack = ack_q;
  assign row_ready        = (state_q == StWaitConsume);
  assign protocol_err     = err_q;

endmodule

// File: tb/tb_cnn_layer_accel_prefetch_ctrl.sv
// Directed self-checking bench for the row prefetch controller.
module tb_cnn_layer_accel_prefetch_ctrl;
  localparam int PW = 16;
  localparam int CW = 10;
  localparam int AW = 32;

  logic          wr_clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_start = 1'b0;
  logic [AW-1:0] job_base_addr = '0;
  logic [AW-1:0] job_row_stride = '0;
  logic [CW-1:0] job_num_cols = '0;
  logic [CW-1:0] job_num_rows = '0;
  logic          job_busy, job_done, mem_req_valid, mem_rsp_ready;
  logic          mem_req_ready = 1'b1;
  logic [AW-1:0] mem_req_addr;
  logic [CW-1:0] mem_req_len;
  logic          mem_rsp_valid = 1'b0;
  logic [PW-1:0] mem_rsp_data = '0;
  logic [PW-1:0] pb_din;
  logic          pb_wr_en, pb_job_fetch_ack, row_ready, protocol_err;
  logic          row_consumed = 1'b0;

  cnn_layer_accel_prefetch_ctrl #(
    .PIXEL_WIDTH(PW), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)
  ) dut (
    .wr_clk(wr_clk), .rst(rst), .job_start(job_start), .job_base_addr(job_base_addr),
    .job_row_stride(job_row_stride), .job_num_cols(job_num_cols),
    .job_num_rows(job_num_rows), .job_busy(job_busy), .job_done(job_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_ready(mem_rsp_ready), .pb_din(pb_din), .pb_wr_en(pb_wr_en),
    .pb_job_fetch_ack(pb_job_fetch_ack), .row_ready(row_ready),
    .row_consumed(row_consumed), .protocol_err(protocol_err)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] pix_q[$];
  logic [AW-1:0] req_addr_q[$];
  logic [CW-1:0] req_len_q[$];
  int ack_cnt, done_cnt, reqv_cnt, overlap_cnt;

  // Passive monitor, sampled mid-cycle while inputs and outputs are stable.
  always @(negedge wr_clk) begin
    if (!rst) begin
      if (pb_wr_en) pix_q.push_back(pb_din);
      if (pb_job_fetch_ack) ack_cnt++;
      if (job_done) done_cnt++;
      if (mem_req_valid) reqv_cnt++;
      if (pb_wr_en && pb_job_fetch_ack) overlap_cnt++;
      if (mem_req_valid && mem_req_ready) begin
        req_addr_q.push_back(mem_req_addr);
        req_len_q.push_back(mem_req_len);
      end
    end
  end

  task automatic clear_mon();
    pix_q.delete(); req_addr_q.delete(); req_len_q.delete();
    ack_cnt = 0; done_cnt = 0; reqv_cnt = 0; overlap_cnt = 0;
  endtask

  task automatic step();
    @(posedge wr_clk); #1;
  endtask

  task automatic start_job(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input logic [CW-1:0] cols, input logic [CW-1:0] rows);
    job_base_addr = base; job_row_stride = stride;
    job_num_cols = cols; job_num_rows = rows;
    job_start = 1'b1;
    step();
    job_start = 1'b0;
  endtask

  task automatic consume();
    row_consumed = 1'b1;
    step();
    row_consumed = 1'b0;
  endtask

  // Memory responder: presents beats first, first+1, ... and advances only on handshake.
  task automatic feed_row(input int n, input logic [PW-1:0] first, input bit toggle);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < 200) begin
      mem_rsp_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      mem_rsp_data  = mem_rsp_valid ? first + PW'(i) : 16'hDEAD;
      if (mem_rsp_valid && mem_rsp_ready) i++;
      step();
      cyc++;
    end
    mem_rsp_valid = 1'b0;
    checks++;
    if (i != n) begin
      errors++;
      $display("FAIL feed_row_timeout: beats %0d required %0d", i, n);
    end
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if ({job_busy, job_done, mem_req_valid, mem_req_addr, mem_req_len, mem_rsp_ready, pb_din,
         pb_wr_en, pb_job_fetch_ack, row_ready, protocol_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {job_busy, job_done, mem_req_valid,
               mem_req_addr, mem_req_len, mem_rsp_ready, pb_din, pb_wr_en, pb_job_fetch_ack,
               row_ready, protocol_err});
    end
    rst = 1'b0;
    step();
    checks++;
    if (job_busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy %b required 0", job_busy);
    end
  endtask

  task automatic test_single_row();
    clear_mon();
    start_job(32'h1000, 32'h0, 10'd4, 10'd1);
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_len, pb_job_fetch_ack, job_busy}
        !== {1'b1, 32'h1000, 10'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL single_req: valid %b addr %h len %0d ack %b, required 1 00001000 4 1",
               mem_req_valid, mem_req_addr, mem_req_len, pb_job_fetch_ack);
    end
    feed_row(4, 16'hA000, 1'b0);
    checks++;
    if ({row_ready, pb_wr_en, pb_din} !== {1'b1, 1'b1, 16'hA003}) begin
      errors++;
      $display("FAIL single_last_write: row_ready %b wr %b din %h required 1 1 a003",
               row_ready, pb_wr_en, pb_din);
    end
    step(); step();
    checks++;
    if ({row_ready, pb_wr_en, mem_req_valid} !== 3'b100) begin
      errors++;
      $display("FAIL single_hold: row_ready %b wr %b reqv %b required 1 0 0",
               row_ready, pb_wr_en, mem_req_valid);
    end
    consume();
    checks++;
    if ({job_done, row_ready} !== 2'b10) begin
      errors++; $display("FAIL single_done: done %b ready %b required 1 0", job_done, row_ready);
    end
    step();
    checks++;
    if ({job_done, job_busy} !== 2'b00) begin
      errors++; $display("FAIL single_idle: done %b busy %b required 0 0", job_done, job_busy);
    end
    checks++;
    if (pix_q.size() != 4 || req_addr_q.size() != 1 || ack_cnt != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL single_counts: pix %0d req %0d ack %0d done %0d required 4 1 1 1",
               pix_q.size(), req_addr_q.size(), ack_cnt, done_cnt);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (pix_q[k] !== 16'hA000 + PW'(k)) begin
          errors++;
          $display("FAIL single_pixel%0d: got %h required %h", k, pix_q[k], 16'hA000 + PW'(k));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_addr;
    clear_mon();
    start_job(32'h1000, 32'h200, 10'd3, 10'd3);
    for (int r = 0; r < 3; r++) begin
      exp_addr = 32'h1000 + 32'(r) * 32'h200;
      checks++;
      if ({mem_req_valid, mem_req_addr, pb_job_fetch_ack} !== {1'b1, exp_addr, 1'b1}) begin
        errors++;
        $display("FAIL rows_req%0d: valid %b addr %h ack %b required 1 %h 1",
                 r, mem_req_valid, mem_req_addr, pb_job_fetch_ack, exp_addr);
      end
      feed_row(3, 16'h1000 + PW'(r * 16), 1'b0);
      if (r == 0) begin
        // A start while busy must not disturb the latched job.
        job_base_addr = 32'hDEAD0000; job_num_cols = 10'd7; job_start = 1'b1;
        step();
        job_start = 1'b0;
      end
      step(); step();
      checks++;
      if ({mem_req_valid, row_ready} !== 2'b01 || req_addr_q.size() != r + 1) begin
        errors++;
        $display("FAIL rows_wait%0d: reqv %b ready %b reqs %0d required 0 1 %0d",
                 r, mem_req_valid, row_ready, req_addr_q.size(), r + 1);
      end
      consume();
    end
    checks++;
    if (job_done !== 1'b1) begin
      errors++; $display("FAIL rows_done: done %b required 1", job_done);
    end
    step();
    checks++;
    if (ack_cnt != 3 || overlap_cnt != 0 || pix_q.size() != 9 || req_len_q.size() != 3) begin
      errors++;
      $display("FAIL rows_counts: ack %0d overlap %0d pix %0d reqs %0d required 3 0 9 3",
               ack_cnt, overlap_cnt, pix_q.size(), req_len_q.size());
    end else begin
      checks++;
      if (pix_q[8] !== 16'h1022 || req_len_q[2] !== 10'd3 || req_addr_q[2] !== 32'h1400) begin
        errors++;
        $display("FAIL rows_content: pix8 %h len2 %0d addr2 %h required 1022 3 00001400",
                 pix_q[8], req_len_q[2], req_addr_q[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_mon();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 16'hBAD0;
    start_job(32'h2468, 32'h0, 10'd5, 10'd1);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({mem_req_valid, mem_req_addr, mem_req_len, mem_rsp_ready}
          !== {1'b1, 32'h2468, 10'd5, 1'b0}) begin
        errors++;
        $display("FAIL stall%0d: valid %b addr %h len %0d rsp_ready %b required 1 00002468 5 0",
                 k, mem_req_valid, mem_req_addr, mem_req_len, mem_rsp_ready);
      end
      step();
    end
    mem_req_ready = 1'b1;
    feed_row(5, 16'hB000, 1'b1);
    consume();
    step();
    checks++;
    if (pix_q.size() != 5 || req_addr_q.size() != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_counts: pix %0d reqs %0d done %0d required 5 1 1",
               pix_q.size(), req_addr_q.size(), done_cnt);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (pix_q[k] !== 16'hB000 + PW'(k)) begin
          errors++;
          $display("FAIL bp_pixel%0d: got %h required %h", k, pix_q[k], 16'hB000 + PW'(k));
        end
      end
    end
  endtask

  task automatic test_zero_illegal();
    clear_mon();
    start_job(32'h3000, 32'h0, 10'd4, 10'd0);
    checks++;
    if ({job_busy, job_done, mem_req_valid} !== 3'b110) begin
      errors++;
      $display("FAIL zero_rows: busy %b done %b reqv %b required 1 1 0",
               job_busy, job_done, mem_req_valid);
    end
    step();
    start_job(32'h3000, 32'h0, 10'd0, 10'd2);
    checks++;
    if ({job_done, mem_req_valid} !== 2'b10) begin
      errors++;
      $display("FAIL zero_cols: done %b reqv %b required 1 0", job_done, mem_req_valid);
    end
    step();
    checks++;
    if (reqv_cnt != 0 || done_cnt != 2 || job_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_counts: reqv %0d done %0d busy %b required 0 2 0",
               reqv_cnt, done_cnt, job_busy);
    end
    consume();
    step(); step();
    checks++;
    if ({protocol_err, job_busy} !== 2'b10) begin
      errors++;
      $display("FAIL sticky_err: err %b busy %b required 1 0", protocol_err, job_busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++; $display("FAIL err_clear: err %b required 0", protocol_err);
    end
  endtask

  task automatic test_wrap();
    clear_mon();
    start_job(32'hFFFFFF00, 32'h100, 10'd2, 10'd2);
    feed_row(2, 16'hE000, 1'b0);
    consume();
    checks++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL wrap_addr: valid %b addr %h required 1 00000000", mem_req_valid, mem_req_addr);
    end
    feed_row(2, 16'hE100, 1'b0);
    consume();
    checks++;
    if (job_done !== 1'b1 || req_addr_q.size() != 2) begin
      errors++;
      $display("FAIL wrap_done: done %b reqs %0d required 1 2", job_done, req_addr_q.size());
    end
    step();
  endtask

  task automatic test_reset_mid_stream();
    clear_mon();
    start_job(32'h5000, 32'h0, 10'd4, 10'd1);
    feed_row(2, 16'hC000, 1'b0);
    rst = 1'b1;
    mem_rsp_valid = 1'b1;
    step();
    checks++;
    if ({job_busy, job_done, mem_req_valid, mem_req_addr, mem_req_len, mem_rsp_ready, pb_din,
         pb_wr_en, pb_job_fetch_ack, row_ready, protocol_err} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: busy %b wr %b din %h addr %h len %0d required all 0",
               job_busy, pb_wr_en, pb_din, mem_req_addr, mem_req_len);
    end
    rst = 1'b0;
    mem_rsp_valid = 1'b0;
    pix_q.delete();
    start_job(32'h6000, 32'h0, 10'd4, 10'd1);
    checks++;
    if ({job_busy, mem_req_valid, mem_req_addr} !== {1'b1, 1'b1, 32'h6000}) begin
      errors++;
      $display("FAIL midrst_restart: busy %b reqv %b addr %h required 1 1 00006000",
               job_busy, mem_req_valid, mem_req_addr);
    end
    feed_row(4, 16'hD000, 1'b0);
    consume();
    step();
    checks++;
    if (done_cnt != 1 || pix_q.size() != 4) begin
      errors++;
      $display("FAIL midrst_done: done %0d pix %0d required 1 4", done_cnt, pix_q.size());
    end else begin
      checks++;
      if (pix_q[0] !== 16'hD000 || pix_q[3] !== 16'hD003) begin
        errors++;
        $display("FAIL midrst_pixels: first %h last %h required d000 d003", pix_q[0], pix_q[3]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    test_reset();
    test_single_row();
    test_back_to_back();
    test_backpressure();
    test_zero_illegal();
    test_wrap();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
